// File: rtl/wbs_mem.sv
// Wishbone classic slave backed by a word-addressed memory with byte-lane
// writes, a programmable number of wait states and error termination for
// out-of-range or misaligned accesses.
module wbs_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WC_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;

    logic        latch_en;
    logic        respond;
    logic        mem_we;
    logic [31:0] eff_addr, eff_wdat;
    logic [3:0]  eff_sel;
    logic        eff_we;
    logic [32:0] offset;
    logic        hit;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the response edge is the acceptance edge, so the
    // live bus is used in IDLE and the latched request everywhere else.
    always_comb begin
        eff_addr = (state_q == S_IDLE) ? wbs_addr_i : addr_q;
        eff_wdat = (state_q == S_IDLE) ? wbs_dat_i  : wdat_q;
        eff_sel  = (state_q == S_IDLE) ? wbs_sel_i  : sel_q;
        eff_we   = (state_q == S_IDLE) ? wbs_we_i   : we_q;
        offset   = {1'b0, eff_addr} - {1'b0, BASE_ADDR};
        hit      = !offset[32] && (offset < SPAN) && (eff_addr[1:0] == 2'b00);
        idx      = offset[AW+1:2];
    end

    // Next-state, response generation and memory write enable.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;
        latch_en = 1'b0;
        respond  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    latch_en = 1'b1;
                    cnt_d    = '0;
                    if (WAIT_CYCLES == 0) begin
                        respond = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Dropping cyc aborts, even on the edge that would complete.
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == WC_LAST) begin
                    respond = 1'b1;
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (respond) begin
            if (hit) begin
                ack_d = 1'b1;
                if (!eff_we) begin
                    dat_d = mem[idx];
                end
            end else begin
                err_d = 1'b1;
            end
        end
        mem_we = respond && hit && eff_we && !rst_i;
    end

    // Control state, latched request and registered bus outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            if (latch_en) begin
                addr_q <= wbs_addr_i;
                wdat_q <= wbs_dat_i;
                sel_q  <= wbs_sel_i;
                we_q   <= wbs_we_i;
            end
        end
    end

    // Storage array: byte-lane writes, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (eff_sel[i]) begin
                    mem[idx][8*i +: 8] <= eff_wdat[8*i +: 8];
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_dat_o = dat_q;

endmodule
